// File: rtl/alu_writeback_regfile_if.sv
// Writeback/register-file bundle: ALU result capture,
// operand read ports and debug/status outputs.
interface alu_writeback_regfile_if #(
    parameter int AW = 2,
    parameter int DW = 8
);
    logic          ex_valid;
    logic          ex_write_en;
    logic          ex_flag_en;
    logic [AW-1:0] ex_dest;
    logic [DW-1:0] ALU_out;
    logic          ALU_zero;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          zero_flag;
    logic          wb_valid;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic [15:0]   commit_count;

    modport master (
        output ex_valid, ex_write_en, ex_flag_en, ex_dest,
        output ALU_out, ALU_zero, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, zero_flag,
        input  wb_valid, wb_dest, wb_data, commit_count
    );

    modport slave (
        input  ex_valid, ex_write_en, ex_flag_en, ex_dest,
        input  ALU_out, ALU_zero, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, zero_flag,
        output wb_valid, wb_dest, wb_data, commit_count
    );
endinterface

// File: rtl/alu_writeback_regfile.sv
// Register file with a one-stage writeback pipeline,
// read-port bypass, zero flag and commit counter.
module alu_writeback_regfile #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input logic                   Clk,
    input logic                   Reset,
    alu_writeback_regfile_if.slave bus
);
    localparam int NR = 1 << AW;

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];
    logic          wb_valid_q, wb_valid_d;
    logic          wb_we_q, wb_we_d;
    logic [AW-1:0] wb_dest_q, wb_dest_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          zero_flag_q, zero_flag_d;
    logic [15:0]   commit_count_q, commit_count_d;
    logic          commit;

    assign commit = wb_valid_q && wb_we_q;

    // Next state: retire the pending write, capture the new result.
    always_comb begin
        regs_d         = regs_q;
        wb_valid_d     = 1'b0;
        wb_we_d        = 1'b0;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        zero_flag_d    = zero_flag_q;
        commit_count_d = commit_count_q;
        if (commit) begin
            regs_d[wb_dest_q] = wb_data_q;
            commit_count_d    = commit_count_q + 16'd1;
        end
        if (bus.ex_valid) begin
            wb_valid_d = 1'b1;
            wb_we_d    = bus.ex_write_en;
            wb_dest_d  = bus.ex_dest;
            wb_data_d  = bus.ALU_out;
            if (bus.ex_flag_en) begin
                zero_flag_d = bus.ALU_zero;
            end
        end
    end

    // State registers; reset discards any pending writeback.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_q     <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
            zero_flag_q    <= 1'b0;
            commit_count_q <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_valid_q     <= wb_valid_d;
            wb_we_q        <= wb_we_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            zero_flag_q    <= zero_flag_d;
            commit_count_q <= commit_count_d;
        end
    end

    // Read ports: the in-flight write shadows the array entry.
    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        if (commit && wb_dest_q == bus.rd_addr_a) begin
            bus.rd_data_a = wb_data_q;
        end
        if (commit && wb_dest_q == bus.rd_addr_b) begin
            bus.rd_data_b = wb_data_q;
        end
    end

    assign bus.zero_flag    = zero_flag_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_dest      = wb_dest_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.commit_count = commit_count_q;
endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Self-checking bench: directed vector table, reset corners,
// randomized run against a value-level model, counter wrap.
module tb_alu_writeback_regfile;
    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    alu_writeback_regfile_if #(.AW(2), .DW(8)) bus ();

    alu_writeback_regfile #(.AW(2), .DW(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic       we;
        logic       fe;
        logic [1:0] d;
        logic [7:0] out;
        logic       z;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ezf;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[10];

    // Model: newest value per register, as seen through the ports.
    logic [7:0]  m_vis [4];
    logic        m_pend;
    logic        m_zf;
    logic [15:0] m_cnt;
    logic        m_wbv;
    logic [1:0]  m_wbd;
    logic [7:0]  m_wbdat;

    function automatic vec_t mk(
        input logic v, we, fe, input logic [1:0] d,
        input logic [7:0] out, input logic z,
        input logic [1:0] ra, rb, input logic [7:0] ea, eb,
        input logic ezf, input logic [15:0] ecnt);
        vec_t r;
        r.v = v; r.we = we; r.fe = fe; r.d = d; r.out = out;
        r.z = z; r.ra = ra; r.rb = rb; r.ea = ea; r.eb = eb;
        r.ezf = ezf; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, we, fe,
                         input logic [1:0] d, input logic [7:0] out,
                         input logic z, input logic [1:0] ra, rb);
        bus.ex_valid    = v;
        bus.ex_write_en = we;
        bus.ex_flag_en  = fe;
        bus.ex_dest     = d;
        bus.ALU_out     = out;
        bus.ALU_zero    = z;
        bus.rd_addr_a   = ra;
        bus.rd_addr_b   = rb;
    endtask

    task automatic model_edge(input logic rst);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_vis[i] = 8'h00;
            m_pend = 0; m_zf = 0; m_cnt = 0;
            m_wbv = 0; m_wbd = 0; m_wbdat = 0;
        end else begin
            if (m_pend) m_cnt = m_cnt + 16'd1;
            m_pend = bus.ex_valid && bus.ex_write_en;
            m_wbv  = bus.ex_valid;
            if (bus.ex_valid) begin
                m_wbd   = bus.ex_dest;
                m_wbdat = bus.ALU_out;
                if (bus.ex_flag_en) m_zf = bus.ALU_zero;
                if (bus.ex_write_en) m_vis[bus.ex_dest] = bus.ALU_out;
            end
        end
    endtask

    initial begin
        vecs[0] = mk(1,1,0,2,8'h5A,0, 2,0, 8'h5A,8'h00, 0,16'd0);
        vecs[1] = mk(0,0,0,0,8'h00,0, 2,2, 8'h5A,8'h5A, 0,16'd1);
        vecs[2] = mk(1,1,0,1,8'h11,0, 2,1, 8'h5A,8'h11, 0,16'd1);
        vecs[3] = mk(1,1,0,1,8'h22,0, 2,1, 8'h5A,8'h22, 0,16'd2);
        vecs[4] = mk(0,0,0,0,8'h00,0, 2,1, 8'h5A,8'h22, 0,16'd3);
        vecs[5] = mk(1,0,1,1,8'h00,1, 1,2, 8'h22,8'h5A, 1,16'd3);
        vecs[6] = mk(0,1,1,2,8'hEE,0, 1,2, 8'h22,8'h5A, 1,16'd3);
        vecs[7] = mk(1,1,0,3,8'hAA,0, 3,1, 8'hAA,8'h22, 1,16'd3);
        vecs[8] = mk(1,0,1,0,8'hFF,0, 3,0, 8'hAA,8'h00, 0,16'd4);
        vecs[9] = mk(1,1,1,3,8'hAA,1, 3,0, 8'hAA,8'h00, 1,16'd4);

        Reset = 1'b1;
        drive(0,0,0,0,8'h00,0,0,0);
        tick();
        tick();
        chk("rst_zf", {31'd0, bus.zero_flag}, 0);
        chk("rst_cnt", {16'd0, bus.commit_count}, 0);
        chk("rst_wbv", {31'd0, bus.wb_valid}, 0);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr_a = i[1:0];
            #1;
            chk("rst_reg", {24'd0, bus.rd_data_a}, 0);
        end

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].fe, vecs[i].d,
                  vecs[i].out, vecs[i].z, vecs[i].ra, vecs[i].rb);
            tick();
            chk($sformatf("vec%0d_a", i), {24'd0, bus.rd_data_a},
                {24'd0, vecs[i].ea});
            chk($sformatf("vec%0d_b", i), {24'd0, bus.rd_data_b},
                {24'd0, vecs[i].eb});
            chk($sformatf("vec%0d_zf", i), {31'd0, bus.zero_flag},
                {31'd0, vecs[i].ezf});
            chk($sformatf("vec%0d_cnt", i), {16'd0, bus.commit_count},
                {16'd0, vecs[i].ecnt});
        end

        // Reg 3 <= AA is pending; reset mid-cycle before its commit.
        #2;
        Reset = 1'b1;
        #1;
        chk("async_zf", {31'd0, bus.zero_flag}, 0);
        chk("async_cnt", {16'd0, bus.commit_count}, 0);
        chk("async_wbv", {31'd0, bus.wb_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr_a = i[1:0];
            bus.rd_addr_b = i[1:0];
            #1;
            chk("async_reg_a", {24'd0, bus.rd_data_a}, 0);
            chk("async_reg_b", {24'd0, bus.rd_data_b}, 0);
        end
        drive(0,0,0,0,8'h00,0,3,3);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_r3", {24'd0, bus.rd_data_a}, 0);
        chk("post_rst_cnt", {16'd0, bus.commit_count}, 0);

        model_edge(1'b1);
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  8'($urandom), $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            Reset = ($urandom_range(0, 99) == 0);
            tick();
            model_edge(Reset);
            Reset = 1'b0;
            chk("rnd_a", {24'd0, bus.rd_data_a},
                {24'd0, m_vis[bus.rd_addr_a]});
            chk("rnd_b", {24'd0, bus.rd_data_b},
                {24'd0, m_vis[bus.rd_addr_b]});
            chk("rnd_zf", {31'd0, bus.zero_flag}, {31'd0, m_zf});
            chk("rnd_cnt", {16'd0, bus.commit_count}, {16'd0, m_cnt});
            chk("rnd_wbv", {31'd0, bus.wb_valid}, {31'd0, m_wbv});
            if (m_wbv) begin
                chk("rnd_wbd", {30'd0, bus.wb_dest}, {30'd0, m_wbd});
                chk("rnd_wbdat", {24'd0, bus.wb_data}, {24'd0, m_wbdat});
            end
        end

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1,1,0,1,8'h33,0,1,1);
        for (int n = 0; n < 65535; n++) tick();
        drive(0,0,0,0,8'h00,0,1,1);
        tick();
        chk("cnt_ffff", {16'd0, bus.commit_count}, 32'h0000FFFF);
        drive(1,1,0,2,8'h44,0,2,1);
        tick();
        drive(0,0,0,0,8'h00,0,2,1);
        tick();
        chk("cnt_wrap", {16'd0, bus.commit_count}, 0);
        chk("wrap_reg2", {24'd0, bus.rd_data_a}, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_writeback_regfile.md
Name: alu_writeback_regfile

Overview:
- Register file plus one-stage writeback pipeline around the ALU. Downstream of the ALU, it captures the ALU result and zero flag.
- Upstream of the ALU, it supplies both operands through two combinational read ports, with bypass of the in-flight writeback.
- Holds the architectural zero flag for branch logic.
- Counts committed register writes for debug and performance visibility.

Parameters:
- AW, 2, register address width; the file holds 2**AW registers.
- DW, 8, data width; matches the ALU data width.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, asynchronous active-high reset.
- ex_valid, input, 1, ALU result on ALU_out/ALU_zero is valid this cycle.
- ex_write_en, input, 1, the result is written to register ex_dest.
- ex_flag_en, input, 1, the result updates zero_flag.
- ex_dest, input, AW, destination register index.
- ALU_out, input, DW, ALU Output.
- ALU_zero, input, 1, ALU Zero.
- rd_addr_a, input, AW, read port A index, feeds ALU input1.
- rd_addr_b, input, AW, read port B index, feeds ALU input2.
- rd_data_a, output, DW, read port A data (combinational).
- rd_data_b, output, DW, read port B data (combinational).
- zero_flag, output, 1, registered architectural zero flag.
- wb_valid, output, 1, writeback stage holds a pending result.
- wb_dest, output, AW, writeback stage destination.
- wb_data, output, DW, writeback stage data.
- commit_count, output, 16, wrapping count of register writes committed to the array.

Behaviour:

Reset (asynchronous, Reset=1):
- All 2**AW registers = 0.
- wb_valid = 0, wb_we = 0 (internal), wb_dest = 0, wb_data = 0.
- zero_flag = 0, commit_count = 0.
- Reset asserted mid-operation discards any pending writeback; no commit occurs on the edge where Reset is high.

Writeback stage (every rising edge, Reset=0):
- If ex_valid=1: wb_valid <= 1, wb_we <= ex_write_en, wb_dest <= ex_dest, wb_data <= ALU_out.
- If ex_valid=0: wb_valid <= 0 and wb_we <= 0. wb_dest and wb_data hold.
- ex_write_en, ex_flag_en, ex_dest, ALU_out and ALU_zero are ignored when ex_valid=0.

Commit (same edge):
- If wb_valid=1 and wb_we=1: regs[wb_dest] <= wb_data, and commit_count <= commit_count + 1.
- commit_count wraps from 16'hFFFF to 0.
- Commit and capture happen on the same edge, so back-to-back valid results stream at one per cycle.
- Latency: a result presented at edge N reaches the array at edge N+1.

Zero flag:
- At an edge with ex_valid=1 and ex_flag_en=1: zero_flag <= ALU_zero.
- Otherwise zero_flag holds.
- The update is independent of ex_write_en; a compare-only operation updates the flag without writing a register.

Read ports (combinational):
- rd_data_x = wb_data if wb_valid && wb_we && wb_dest == rd_addr_x; otherwise rd_data_x = regs[rd_addr_x].
- The bypass makes a result visible on the read ports immediately after the capture edge N, with no stall.
- Both ports may address the same register, or the bypassed register, simultaneously.

Same-destination back-to-back:
- Results to reg r in consecutive cycles both commit, and the later value wins.
- The bypass always returns the newest value.

Test Plan:
- Reset while regs and flags are nonzero -> every register reads 0; zero_flag=0; commit_count=0; wb_valid=0, asynchronously, before the next edge.
- ex_valid=1, ex_write_en=1, ex_dest=2, ALU_out=8'h5A for one cycle; rd_addr_a=2 -> rd_data_a=8'h5A after edge 1 (bypass, wb_valid=1) and after edge 2 (array); commit_count=1.
- Consecutive results to reg 1: 8'h11, then 8'h22 -> rd_data_b (rd_addr_b=1) shows 8'h11 after edge 1 and 8'h22 after edge 2 onward; commit_count=2.
- ex_flag_en=1, ex_write_en=0, ALU_zero=1, ALU_out=8'h00 -> zero_flag=1 after the edge; no register changes; commit_count unchanged. Next, ex_valid=0 with ALU_zero=0 -> zero_flag stays 1.
- Result to reg 3 (8'hAA) accepted, then Reset pulsed before the commit edge -> reg 3 reads 0; commit_count=0.
- Preload commit_count to 16'hFFFF via 65535 writes, then one more write -> commit_count=0.
